// File: rtl/sound_latch_responder.sv
// Z80-side responder for the 68k->Z80 sound command path, with the periodic Z80 interrupt.
// Define SOUND_LATCH_FIFO_EN to replace the single command latch with a FIFO_DEPTH-entry FIFO.
module sound_latch_responder #(
    parameter int IRQ_PERIOD = 24000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] m68k_din,
    input  logic       m68k_rw,
    input  logic       m68k_lds_n,
    input  logic       sound_latch_cs,
    input  logic       z80_latch_r_cs,
    input  logic       z80_latch_clr_cs,
    input  logic       z80_m1_n,
    input  logic       z80_iorq_n,
    output logic [7:0] z80_latch_dout,
    output logic       latch_pending,
    output logic       latch_full,
    output logic       z80_int_n
);

    localparam int CNT_W = $clog2(IRQ_PERIOD);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(IRQ_PERIOD - 1);

    typedef enum logic {IDLE, ASSERTED} irqState_t;

    irqState_t        r_state;
    irqState_t        w_nextState;
    logic [CNT_W-1:0] r_irqCnt;
    logic             r_wqPrev;
    logic             r_clrPrev;
    logic             r_ackPrev;
    logic             w_wq;
    logic             w_ackQual;
    logic             w_wrEvent;
    logic             w_clrEvent;
    logic             w_ackEvent;
    logic             w_tc;

    // A long strobe must yield exactly one write, so every event is a rising edge of its qualifier.
    assign w_wq       = sound_latch_cs & ~m68k_rw & ~m68k_lds_n;
    assign w_ackQual  = ~z80_m1_n & ~z80_iorq_n;
    assign w_wrEvent  = w_wq & ~r_wqPrev;
    assign w_clrEvent = z80_latch_clr_cs & ~r_clrPrev;
    assign w_ackEvent = w_ackQual & ~r_ackPrev;
    assign w_tc       = (r_irqCnt == TC_VAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wqPrev  <= 1'b0;
            r_clrPrev <= 1'b0;
            r_ackPrev <= 1'b0;
        end else begin
            r_wqPrev  <= w_wq;
            r_clrPrev <= z80_latch_clr_cs;
            r_ackPrev <= w_ackQual;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irqCnt <= '0;
            r_state  <= IDLE;
        end else begin
            r_irqCnt <= w_tc ? '0 : r_irqCnt + 1'b1;
            r_state  <= w_nextState;
        end
    end

    // Terminal count outranks an acknowledge landing in the same cycle.
    always_comb begin
        w_nextState = r_state;
        if (w_tc) begin
            w_nextState = ASSERTED;
        end else if (r_state == ASSERTED && w_ackEvent) begin
            w_nextState = IDLE;
        end
    end

    assign z80_int_n = (r_state != ASSERTED);

`ifdef SOUND_LATCH_FIFO_EN

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(FIFO_DEPTH);

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [FCNT_W-1:0] r_count;
    logic              r_rdPrev;
    logic              w_pop;
    logic              w_push;
    logic [PTR_W-1:0]  w_wrIdx;

    // Pops happen when the Z80 read ends; a clear flushes first so a coinciding push lands in slot 0.
    assign w_pop   = r_rdPrev & ~z80_latch_r_cs & (r_count != '0);
    assign w_push  = w_wrEvent & (w_clrEvent | (r_count != DEPTH_C) | w_pop);
    assign w_wrIdx = w_clrEvent ? '0 : r_wrPtr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wrIdx] <= m68k_din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdPtr  <= '0;
            r_wrPtr  <= '0;
            r_count  <= '0;
            r_rdPrev <= 1'b0;
        end else begin
            r_rdPrev <= z80_latch_r_cs;
            if (w_clrEvent) begin
                r_rdPtr <= '0;
                r_wrPtr <= w_push ? PTR_W'(1) : '0;
                r_count <= w_push ? FCNT_W'(1) : '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + 1'b1;
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign z80_latch_dout = (r_count != '0) ? r_mem[r_rdPtr] : 8'h00;
    assign latch_pending  = (r_count != '0);
    assign latch_full     = (r_count == DEPTH_C);

`else

    logic [7:0]  r_latch;
    logic        r_pending;
    logic        w_unusedRd;
    logic [31:0] w_unusedDepth;

    // Reads are non-destructive here; the read select and FIFO depth only matter in FIFO builds.
    assign w_unusedRd    = z80_latch_r_cs;
    assign w_unusedDepth = 32'(FIFO_DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_latch   <= 8'h00;
            r_pending <= 1'b0;
        end else if (w_wrEvent) begin
            r_latch   <= m68k_din;
            r_pending <= 1'b1;
        end else if (w_clrEvent) begin
            r_latch   <= 8'h00;
            r_pending <= 1'b0;
        end
    end

    assign z80_latch_dout = r_latch;
    assign latch_pending  = r_pending;
    assign latch_full     = r_pending;

`endif

endmodule

// File: tb/tb_sound_latch_responder.sv
// Directed self-checking bench for sound_latch_responder (IRQ_PERIOD=16, FIFO_DEPTH=4).
// Covers the single-latch build by default and the FIFO build when SOUND_LATCH_FIFO_EN is defined.
module tb_sound_latch_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] m68k_din = 8'h00;
    logic       m68k_rw = 1'b1;
    logic       m68k_lds_n = 1'b1;
    logic       sound_latch_cs = 1'b0;
    logic       z80_latch_r_cs = 1'b0;
    logic       z80_latch_clr_cs = 1'b0;
    logic       z80_m1_n = 1'b1;
    logic       z80_iorq_n = 1'b1;
    logic [7:0] z80_latch_dout;
    logic       latch_pending;
    logic       latch_full;
    logic       z80_int_n;

    int checks = 0;
    int errors = 0;

    sound_latch_responder #(
        .IRQ_PERIOD(16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .m68k_din         (m68k_din),
        .m68k_rw          (m68k_rw),
        .m68k_lds_n       (m68k_lds_n),
        .sound_latch_cs   (sound_latch_cs),
        .z80_latch_r_cs   (z80_latch_r_cs),
        .z80_latch_clr_cs (z80_latch_clr_cs),
        .z80_m1_n         (z80_m1_n),
        .z80_iorq_n       (z80_iorq_n),
        .z80_latch_dout   (z80_latch_dout),
        .latch_pending    (latch_pending),
        .latch_full       (latch_full),
        .z80_int_n        (z80_int_n)
    );

    always #5 clk = ~clk;

    // Single point of comparison so every check is counted the same way.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s got 0x%02h expected 0x%02h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cs, input logic rw, input logic ldsN, input logic [7:0] din,
                                 input logic rd, input logic clr, input logic m1N, input logic iorqN);
        sound_latch_cs   = cs;
        m68k_rw          = rw;
        m68k_lds_n       = ldsN;
        m68k_din         = din;
        z80_latch_r_cs   = rd;
        z80_latch_clr_cs = clr;
        z80_m1_n         = m1N;
        z80_iorq_n       = iorqN;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic writeByte(input logic [7:0] d);
        applyStimulus(1'b1, 1'b0, 1'b0, d, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        tick();
    endtask

    task automatic readPort();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        tick();
    endtask

    task automatic clearPort();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        tick();
    endtask

    initial begin
        logic [7:0] expA [4];
        logic [7:0] expB [4];
        int waitCnt;
        expA = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        expB = '{8'hB2, 8'hB3, 8'hB4, 8'hB5};

        // Reset state and a single write with a long strobe.
        idle();
        #2;
        checkOutput("rstDout", z80_latch_dout, 8'h00);
        checkOutput("rstPending", {7'b0, latch_pending}, 8'h00);
        checkOutput("rstFull", {7'b0, latch_full}, 8'h00);
        checkOutput("rstIntN", {7'b0, z80_int_n}, 8'h01);
        tick();
        reset = 1'b0;
        tick();

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("wrDout", z80_latch_dout, 8'h5A);
        checkOutput("wrPending", {7'b0, latch_pending}, 8'h01);
        m68k_din = 8'hFF;
        tick();
        tick();
        tick();
        checkOutput("wrHeldOnce", z80_latch_dout, 8'h5A);
        idle();
        tick();

        applyStimulus(1'b1, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        checkOutput("upperOnly", z80_latch_dout, 8'h5A);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hDD, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        checkOutput("readCycle", z80_latch_dout, 8'h5A);

`ifndef SOUND_LATCH_FIFO_EN
        // Overwrite, non-destructive reads, clear, and write winning over clear.
        writeByte(8'h11);
        writeByte(8'h22);
        checkOutput("ovrDout", z80_latch_dout, 8'h22);
        checkOutput("ovrFull", {7'b0, latch_full}, 8'h01);
        readPort();
        checkOutput("rd1Dout", z80_latch_dout, 8'h22);
        readPort();
        checkOutput("rd2Dout", z80_latch_dout, 8'h22);
        checkOutput("rd2Pending", {7'b0, latch_pending}, 8'h01);
        clearPort();
        checkOutput("clrDout", z80_latch_dout, 8'h00);
        checkOutput("clrPending", {7'b0, latch_pending}, 8'h00);
        checkOutput("clrFull", {7'b0, latch_full}, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("wrClrDout", z80_latch_dout, 8'h77);
        checkOutput("wrClrPending", {7'b0, latch_pending}, 8'h01);
        idle();
        tick();
`else
        // FIFO fill, overflow drop, in-order drain, empty pop, push+pop when full, clear+push.
        clearPort();
        checkOutput("flushPending", {7'b0, latch_pending}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            writeByte(expA[i]);
            checkOutput("fillFull", {7'b0, latch_full}, (i == 3) ? 8'h01 : 8'h00);
        end
        writeByte(8'hA5);
        checkOutput("ovfFull", {7'b0, latch_full}, 8'h01);
        checkOutput("ovfHead", z80_latch_dout, 8'hA1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drainHead", z80_latch_dout, expA[i]);
            readPort();
        end
        checkOutput("emptyPending", {7'b0, latch_pending}, 8'h00);
        checkOutput("emptyDout", z80_latch_dout, 8'h00);
        readPort();
        checkOutput("popEmptyPending", {7'b0, latch_pending}, 8'h00);
        checkOutput("popEmptyFull", {7'b0, latch_full}, 8'h00);
        checkOutput("popEmptyDout", z80_latch_dout, 8'h00);
        writeByte(8'hB1);
        checkOutput("afterEmptyHead", z80_latch_dout, 8'hB1);
        writeByte(8'hB2);
        writeByte(8'hB3);
        writeByte(8'hB4);
        checkOutput("refillFull", {7'b0, latch_full}, 8'h01);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hB5, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        checkOutput("pushPopFull", {7'b0, latch_full}, 8'h01);
        for (int i = 0; i < 4; i++) begin
            checkOutput("pushPopOrder", z80_latch_dout, expB[i]);
            readPort();
        end
        checkOutput("pushPopEmpty", {7'b0, latch_pending}, 8'h00);
        writeByte(8'hC1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hC2, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        checkOutput("clrPushHead", z80_latch_dout, 8'hC2);
        readPort();
        checkOutput("clrPushOnlyOne", {7'b0, latch_pending}, 8'h00);
`endif

        // Asynchronous reset while INT is asserted and a command is pending.
        writeByte(8'h3C);
        waitCnt = 0;
        while (z80_int_n !== 1'b0 && waitCnt < 40) begin
            tick();
            waitCnt++;
        end
        checkOutput("preRstIntN", {7'b0, z80_int_n}, 8'h00);
        checkOutput("preRstPending", {7'b0, latch_pending}, 8'h01);
        reset = 1'b1;
        #1;
        checkOutput("midRstIntN", {7'b0, z80_int_n}, 8'h01);
        checkOutput("midRstPending", {7'b0, latch_pending}, 8'h00);
        checkOutput("midRstDout", z80_latch_dout, 8'h00);
        tick();
        reset = 1'b0;

        // IRQ timing from a freshly reset counter: edges counted from reset release.
        for (int i = 0; i < 15; i++) tick();
        checkOutput("irqEdge15", {7'b0, z80_int_n}, 8'h01);
        tick();
        checkOutput("irqEdge16", {7'b0, z80_int_n}, 8'h00);
        for (int i = 0; i < 24; i++) tick();
        checkOutput("irqHeld40", {7'b0, z80_int_n}, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("ackRelease", {7'b0, z80_int_n}, 8'h01);
        idle();
        for (int i = 0; i < 6; i++) tick();
        checkOutput("irqEdge47", {7'b0, z80_int_n}, 8'h01);
        tick();
        checkOutput("irqEdge48", {7'b0, z80_int_n}, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("ioNoAck", {7'b0, z80_int_n}, 8'h00);
        idle();
        for (int i = 0; i < 13; i++) tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("tcBeatsAck", {7'b0, z80_int_n}, 8'h00);
        idle();
        tick();
        checkOutput("tcBeatsAckHold", {7'b0, z80_int_n}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_latch_responder.md
Name: sound_latch_responder

Overview:
- Z80-side responder for the 68k→Z80 sound command path.
- Captures 68k byte writes qualified by sound_latch_cs and presents the byte to the Z80 on latch-read port 0x06.
- Clears the byte on any access to latch-clear port 0x04.
- Generates the periodic Z80 maskable interrupt, held until the Z80 interrupt-acknowledge cycle.

Parameters:
- IRQ_PERIOD, 24000: clk cycles between Z80 interrupt assertions; must be ≥2.
- FIFO_DEPTH, 4: command FIFO entries, power of two; used only with SOUND_LATCH_FIFO_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- m68k_din  in  8  68k data bus low byte D[7:0]
- m68k_rw  in  1  68k R/W (1 = read)
- m68k_lds_n  in  1  68k lower data strobe, active-low
- sound_latch_cs  in  1  68k sound latch select (address-decoded, AS-qualified)
- z80_latch_r_cs  in  1  Z80 IO read select, port 0x06 (IORQ-qualified)
- z80_latch_clr_cs  in  1  Z80 IO select, port 0x04 (IORQ-qualified)
- z80_m1_n  in  1  Z80 M1, active-low
- z80_iorq_n  in  1  Z80 IORQ, active-low
- z80_latch_dout  out  8  byte returned to the Z80 data bus
- latch_pending  out  1  unread command present
- latch_full  out  1  no space for a further write
- z80_int_n  out  1  Z80 INT, active-low

Behaviour:
- Reset (async, immediate): latch/FIFO empty, z80_latch_dout=0x00, latch_pending=0, latch_full=0, z80_int_n=1, IRQ counter=0, all edge-detect registers=0. Reset asserted mid-operation aborts everything, including pending IRQ.
- Write qualifier wq = sound_latch_cs & !m68k_rw & !m68k_lds_n.
  - Write event = rising edge of wq (wq=1 this cycle, 0 previous cycle). One event per bus cycle regardless of strobe length.
  - Byte-wide only; upper-byte-only writes (LDS_n=1) ignored.
- Single-latch mode (macro off):
  - Write event: latch←m68k_din and pending←1 on that edge; dout valid the next cycle.
  - Write while pending=1 overwrites the latch; no queueing.
  - latch_full = latch_pending.
- Clear event = rising edge of z80_latch_clr_cs: latch←0x00, pending←0.
- Write event and clear event in the same cycle: write wins (new data, pending=1).
- Port 0x06 read:
  - z80_latch_dout is driven combinationally from the latch register at all times.
  - Reads do not change state in single-latch mode.
- IRQ FSM, states IDLE / ASSERTED:
  - Counter runs 0..IRQ_PERIOD-1 and wraps; it runs continuously in both states.
  - Terminal count (counter==IRQ_PERIOD-1) → ASSERTED, z80_int_n=0 from the next cycle.
  - Ack event = rising edge of (!z80_m1_n & !z80_iorq_n) → IDLE, z80_int_n=1 next cycle.
  - Terminal count while already ASSERTED: stay ASSERTED; ticks are not counted or queued.
  - Terminal count and ack in the same cycle: ASSERTED wins.
  - An IO access alone (M1_n=1) never acknowledges.

Optional Feature:
- Macro: SOUND_LATCH_FIFO_EN.
- Defined:
  - Replaces the latch with a FIFO_DEPTH-entry FIFO.
  - Write event pushes the byte; push when full is dropped and state is unchanged.
  - z80_latch_dout = head entry; 0x00 when empty.
  - Pop occurs on the falling edge of z80_latch_r_cs (end of the IO read), only if non-empty. Pop on empty: no-op, no pointer wrap corruption.
  - Clear event flushes all entries.
  - Simultaneous push and pop: both take effect, count unchanged; if full, the pop frees space so the push is accepted.
  - Simultaneous clear and push: FIFO ends holding only the pushed byte.
  - latch_pending = count≠0; latch_full = count==FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
- Undefined: single-latch behaviour above; FIFO_DEPTH ignored.

Test Plan:
- Reset, then 68k write 0x5A with wq held 4 cycles → z80_latch_dout=0x5A one cycle after the edge, pending=1, exactly one write event.
- Write 0x11 then 0x22 (macro off), port 0x06 read twice → both return 0x22; a clr access → dout=0x00, pending=0; write coinciding with clr → dout=new byte, pending=1.
- IRQ_PERIOD=16, no ack for 40 cycles → z80_int_n falls at cycle 16 and stays low; M1_n=0 & IORQ_n=0 pulse → z80_int_n=1 next cycle, falls again at the next terminal count; M1_n=1 IO cycle leaves INT low.
- Macro on, depth 4: push 0xA1..0xA5 → full=1 after four, 0xA5 dropped; four reads return A1,A2,A3,A4, then pending=0, dout=0x00; fifth read is a no-op.
- Macro on, full FIFO, push coinciding with read-end pop → push accepted, count stays 4, order preserved.
- Assert reset while INT low and pending=1 → z80_int_n=1, pending=0, dout=0x00 immediately; counter restarts at 0.
